// File: rtl/pipelined_id_exe_if.sv
// Operand/control bundle between the ID stage, the ID/EXE register and the execute stage.
// The master drives the ID- and MEM-side inputs; the slave (the ID/EXE block) drives the EXE-side outputs.
interface pipelined_id_exe_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic [WIDTH-1:0] ID_Qa, ID_Qb, ID_Ext_imm, ID_PC_plus4;
  logic [RADDR-1:0] ID_Rs, ID_Rt, ID_write_reg;
  logic             ID_Use_rs, ID_Use_rt;
  logic [1:0]       ID_Aluc;
  logic             ID_Aluqb, ID_Wreg, ID_Reg2reg, ID_Wmem, ID_Valid;
  logic             Flush;
  logic [WIDTH-1:0] EXE_Alu, MEM_Alu, MEM_Mdata;
  logic             MEM_Wreg, MEM_Reg2reg;
  logic [RADDR-1:0] MEM_write_reg;
  logic [WIDTH-1:0] EXE_Qa, EXE_Qb, EXE_Ext_imm, EXE_PC_plus4;
  logic [RADDR-1:0] EXE_write_reg;
  logic [1:0]       EXE_Aluc;
  logic             EXE_Aluqb, EXE_Wreg, EXE_Reg2reg, EXE_Wmem, EXE_Valid;
  logic [1:0]       FwdA, FwdB;
  logic             Stall;

  modport master (
    output ID_Qa, ID_Qb, ID_Ext_imm, ID_PC_plus4, ID_Rs, ID_Rt, ID_write_reg,
           ID_Use_rs, ID_Use_rt, ID_Aluc, ID_Aluqb, ID_Wreg, ID_Reg2reg, ID_Wmem,
           ID_Valid, Flush, EXE_Alu, MEM_Alu, MEM_Mdata, MEM_Wreg, MEM_Reg2reg,
           MEM_write_reg,
    input  EXE_Qa, EXE_Qb, EXE_Ext_imm, EXE_PC_plus4, EXE_write_reg, EXE_Aluc,
           EXE_Aluqb, EXE_Wreg, EXE_Reg2reg, EXE_Wmem, EXE_Valid, FwdA, FwdB, Stall
  );

  modport slave (
    input  ID_Qa, ID_Qb, ID_Ext_imm, ID_PC_plus4, ID_Rs, ID_Rt, ID_write_reg,
           ID_Use_rs, ID_Use_rt, ID_Aluc, ID_Aluqb, ID_Wreg, ID_Reg2reg, ID_Wmem,
           ID_Valid, Flush, EXE_Alu, MEM_Alu, MEM_Mdata, MEM_Wreg, MEM_Reg2reg,
           MEM_write_reg,
    output EXE_Qa, EXE_Qb, EXE_Ext_imm, EXE_PC_plus4, EXE_write_reg, EXE_Aluc,
           EXE_Aluqb, EXE_Wreg, EXE_Reg2reg, EXE_Wmem, EXE_Valid, FwdA, FwdB, Stall
  );
endinterface

// File: rtl/pipelined_id_exe.sv
// ID-stage operand forwarding, load-use stall detection and the ID/EXE pipeline register.
// Flush and Stall both load an all-zero bubble, so a bubble can never write registers or memory.
module pipelined_id_exe #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input logic               Clk,
  input logic               Rst,
  pipelined_id_exe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] ext_imm;
    logic [WIDTH-1:0] pc_plus4;
    logic [RADDR-1:0] write_reg;
    logic [1:0]       aluc;
    logic             aluqb;
    logic             wreg;
    logic             reg2reg;
    logic             wmem;
    logic             valid;
  } exe_reg_t;

  exe_reg_t exe_q, exe_d;
  logic     stall;

  // Operand 0 is A (rs/Qa), operand 1 is B (rt/Qb); the forwarding logic is identical.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [RADDR-1:0] rn;
    logic             use_src;
    logic [WIDTH-1:0] q_rf;
    logic             exe_hit, mem_hit, ld_hit;
    logic [1:0]       sel;
    logic [WIDTH-1:0] q;

    assign rn      = (gi == 0) ? bus.ID_Rs     : bus.ID_Rt;
    assign use_src = (gi == 0) ? bus.ID_Use_rs : bus.ID_Use_rt;
    assign q_rf    = (gi == 0) ? bus.ID_Qa     : bus.ID_Qb;

    // EXE forwarding needs the operand to be read; MEM forwarding only checks the register match.
    assign exe_hit = use_src && exe_q.valid && exe_q.wreg && !exe_q.reg2reg &&
                     (exe_q.write_reg == rn) && (rn != '0);
    assign mem_hit = bus.MEM_Wreg && (bus.MEM_write_reg == rn) && (rn != '0);
    assign ld_hit  = use_src && (exe_q.write_reg == rn);

    always_comb begin
      sel = 2'd0;
      if (exe_hit)
        sel = 2'd1;
      else if (mem_hit)
        sel = bus.MEM_Reg2reg ? 2'd3 : 2'd2;
    end

    always_comb begin
      q = q_rf;
      case (sel)
        2'd1:    q = bus.EXE_Alu;
        2'd2:    q = bus.MEM_Alu;
        2'd3:    q = bus.MEM_Mdata;
        default: q = q_rf;
      endcase
    end
  end

  assign stall = bus.ID_Valid && !bus.Flush && exe_q.valid && exe_q.wreg &&
                 exe_q.reg2reg && (exe_q.write_reg != '0) &&
                 (g_fwd[0].ld_hit || g_fwd[1].ld_hit);

  always_comb begin
    exe_d = '0;
    if (!bus.Flush && !stall) begin
      exe_d.qa        = g_fwd[0].q;
      exe_d.qb        = g_fwd[1].q;
      exe_d.ext_imm   = bus.ID_Ext_imm;
      exe_d.pc_plus4  = bus.ID_PC_plus4;
      exe_d.write_reg = bus.ID_write_reg;
      exe_d.aluc      = bus.ID_Aluc;
      exe_d.aluqb     = bus.ID_Aluqb;
      exe_d.wreg      = bus.ID_Wreg && bus.ID_Valid;
      exe_d.reg2reg   = bus.ID_Reg2reg;
      exe_d.wmem      = bus.ID_Wmem && bus.ID_Valid;
      exe_d.valid     = bus.ID_Valid;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      exe_q <= '0;
    else
      exe_q <= exe_d;
  end

  assign bus.EXE_Qa        = exe_q.qa;
  assign bus.EXE_Qb        = exe_q.qb;
  assign bus.EXE_Ext_imm   = exe_q.ext_imm;
  assign bus.EXE_PC_plus4  = exe_q.pc_plus4;
  assign bus.EXE_write_reg = exe_q.write_reg;
  assign bus.EXE_Aluc      = exe_q.aluc;
  assign bus.EXE_Aluqb     = exe_q.aluqb;
  assign bus.EXE_Wreg      = exe_q.wreg;
  assign bus.EXE_Reg2reg   = exe_q.reg2reg;
  assign bus.EXE_Wmem      = exe_q.wmem;
  assign bus.EXE_Valid     = exe_q.valid;
  assign bus.FwdA          = g_fwd[0].sel;
  assign bus.FwdB          = g_fwd[1].sel;
  assign bus.Stall         = stall;

endmodule

// File: tb/tb_pipelined_id_exe.sv
// Directed bench for pipelined_id_exe: reset, forwarding priority, load-use stall, r0 guard and flush.
module tb_pipelined_id_exe;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipelined_id_exe_if #(.WIDTH(32), .RADDR(5)) bus ();

  pipelined_id_exe #(.WIDTH(32), .RADDR(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic id_clear();
    bus.ID_Qa = '0; bus.ID_Qb = '0; bus.ID_Ext_imm = '0; bus.ID_PC_plus4 = '0;
    bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_write_reg = '0;
    bus.ID_Use_rs = 0; bus.ID_Use_rt = 0; bus.ID_Aluc = '0; bus.ID_Aluqb = 0;
    bus.ID_Wreg = 0; bus.ID_Reg2reg = 0; bus.ID_Wmem = 0; bus.ID_Valid = 0;
    bus.Flush = 0;
  endtask

  task automatic mem_clear();
    bus.MEM_Alu = '0; bus.MEM_Mdata = '0; bus.MEM_Wreg = 0;
    bus.MEM_Reg2reg = 0; bus.MEM_write_reg = '0; bus.EXE_Alu = '0;
  endtask

  // Present a register-writing instruction in ID that reads nothing.
  task automatic id_writer(input logic [4:0] rd, input logic is_load);
    id_clear();
    bus.ID_Valid = 1; bus.ID_Wreg = 1; bus.ID_Reg2reg = is_load;
    bus.ID_write_reg = rd; bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd2;
  endtask

  initial begin
    // Reset with garbage on every input.
    id_clear(); mem_clear();
    bus.ID_Qa = 32'hFFFF_FFFF; bus.ID_Qb = 32'hAAAA_5555; bus.ID_Ext_imm = 32'h1234;
    bus.ID_PC_plus4 = 32'h400; bus.ID_write_reg = 5'd9; bus.ID_Aluc = 2'd3;
    bus.ID_Aluqb = 1; bus.ID_Wreg = 1; bus.ID_Reg2reg = 1; bus.ID_Wmem = 1; bus.ID_Valid = 1;
    Rst = 1;
    tick();
    check("rst_valid", {31'd0, bus.EXE_Valid}, 32'd0);
    check("rst_qa", bus.EXE_Qa, 32'd0);
    check("rst_qb", bus.EXE_Qb, 32'd0);
    check("rst_imm", bus.EXE_Ext_imm, 32'd0);
    check("rst_pc", bus.EXE_PC_plus4, 32'd0);
    check("rst_ctrl", {22'd0, bus.EXE_write_reg, bus.EXE_Aluc, bus.EXE_Aluqb,
                       bus.EXE_Wreg, bus.EXE_Reg2reg, bus.EXE_Wmem}, 32'd0);
    Rst = 0;

    // EXE forward: add r3 into EXE, then ID reads rs=3.
    id_writer(5'd3, 0);
    bus.ID_PC_plus4 = 32'h104; bus.ID_Ext_imm = 32'h22;
    tick();
    check("add_valid", {31'd0, bus.EXE_Valid}, 32'd1);
    check("add_wr", {27'd0, bus.EXE_write_reg}, 32'd3);
    check("add_pc", bus.EXE_PC_plus4, 32'h104);
    id_clear();
    bus.ID_Valid = 1; bus.ID_Use_rs = 1; bus.ID_Rs = 5'd3; bus.ID_Qa = 32'hDEAD;
    bus.ID_Wreg = 1; bus.ID_write_reg = 5'd6;
    bus.EXE_Alu = 32'h0000_0010;
    #1;
    check("exe_fwdA", {30'd0, bus.FwdA}, 32'd1);
    check("exe_stall", {31'd0, bus.Stall}, 32'd0);
    tick();
    check("exe_qa", bus.EXE_Qa, 32'h10);
    check("exe_wr6", {27'd0, bus.EXE_write_reg}, 32'd6);

    // Dual-source priority on rt=5.
    id_writer(5'd5, 0);
    tick();
    id_clear();
    bus.ID_Valid = 1; bus.ID_Use_rt = 1; bus.ID_Rt = 5'd5; bus.ID_Qb = 32'h1111;
    bus.ID_Aluqb = 1; bus.ID_Aluc = 2'd2; bus.ID_write_reg = 5'd5;
    bus.EXE_Alu = 32'd7; bus.MEM_Alu = 32'd9;
    bus.MEM_Wreg = 1; bus.MEM_Reg2reg = 0; bus.MEM_write_reg = 5'd5;
    #1;
    check("prio_fwdB_exe", {30'd0, bus.FwdB}, 32'd1);
    tick();
    check("prio_qb_exe", bus.EXE_Qb, 32'd7);
    check("prio_aluc", {30'd0, bus.EXE_Aluc}, 32'd2);
    check("prio_aluqb", {31'd0, bus.EXE_Aluqb}, 32'd1);
    check("prio_wreg0", {31'd0, bus.EXE_Wreg}, 32'd0);
    // EXE now holds a non-writing instruction to r5, so MEM wins.
    #1;
    check("prio_fwdB_mem", {30'd0, bus.FwdB}, 32'd2);
    tick();
    check("prio_qb_mem", bus.EXE_Qb, 32'd9);

    // Load-use: lw r4 into EXE, then add reading rs=4.
    mem_clear();
    id_writer(5'd4, 1);
    tick();
    check("lw_r2r", {31'd0, bus.EXE_Reg2reg}, 32'd1);
    id_clear();
    bus.ID_Valid = 1; bus.ID_Use_rs = 1; bus.ID_Rs = 5'd4; bus.ID_Qa = 32'hBEEF;
    bus.ID_Wreg = 1; bus.ID_write_reg = 5'd7;
    #1;
    check("lu_stall", {31'd0, bus.Stall}, 32'd1);
    tick();
    check("lu_bub_valid", {31'd0, bus.EXE_Valid}, 32'd0);
    check("lu_bub_wreg", {31'd0, bus.EXE_Wreg}, 32'd0);
    check("lu_bub_qa", bus.EXE_Qa, 32'd0);
    bus.MEM_Wreg = 1; bus.MEM_Reg2reg = 1; bus.MEM_write_reg = 5'd4;
    bus.MEM_Mdata = 32'h1234; bus.MEM_Alu = 32'h5555;
    #1;
    check("lu_stall_clr", {31'd0, bus.Stall}, 32'd0);
    check("lu_fwdA", {30'd0, bus.FwdA}, 32'd3);
    tick();
    check("lu_qa", bus.EXE_Qa, 32'h1234);
    check("lu_valid", {31'd0, bus.EXE_Valid}, 32'd1);
    check("lu_wr", {27'd0, bus.EXE_write_reg}, 32'd7);

    // r0 guard: EXE writes r0, ID reads r0.
    mem_clear();
    id_writer(5'd0, 0);
    tick();
    id_clear();
    bus.ID_Valid = 1; bus.ID_Use_rs = 1; bus.ID_Rs = 5'd0; bus.ID_Qa = 32'd0;
    bus.EXE_Alu = 32'd5;
    #1;
    check("r0_fwdA", {30'd0, bus.FwdA}, 32'd0);
    tick();
    check("r0_qa", bus.EXE_Qa, 32'd0);
    id_writer(5'd0, 1);
    tick();
    id_clear();
    bus.ID_Valid = 1; bus.ID_Use_rs = 1; bus.ID_Rs = 5'd0;
    #1;
    check("r0_nostall", {31'd0, bus.Stall}, 32'd0);

    // Flush during a load-use condition.
    id_writer(5'd8, 1);
    tick();
    id_clear();
    bus.ID_Valid = 1; bus.ID_Use_rs = 1; bus.ID_Rs = 5'd8; bus.ID_Wreg = 1;
    bus.ID_write_reg = 5'd9; bus.Flush = 1;
    #1;
    check("fl_stall", {31'd0, bus.Stall}, 32'd0);
    tick();
    check("fl_valid", {31'd0, bus.EXE_Valid}, 32'd0);
    check("fl_wr", {27'd0, bus.EXE_write_reg}, 32'd0);

    // Store flushed, then the same store accepted.
    id_clear();
    bus.ID_Valid = 1; bus.ID_Wmem = 1; bus.ID_Use_rt = 1; bus.ID_Rt = 5'd2;
    bus.ID_Qb = 32'h77; bus.Flush = 1;
    tick();
    check("st_fl_wmem", {31'd0, bus.EXE_Wmem}, 32'd0);
    bus.Flush = 0;
    tick();
    check("st_wmem", {31'd0, bus.EXE_Wmem}, 32'd1);
    check("st_qb", bus.EXE_Qb, 32'h77);

    // Mid-stream reset discards the instruction in flight.
    Rst = 1;
    tick();
    check("rst2_valid", {31'd0, bus.EXE_Valid}, 32'd0);
    check("rst2_wmem", {31'd0, bus.EXE_Wmem}, 32'd0);
    Rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_id_exe.md
Name: pipelined_id_exe

Overview:
- Producer side of the execute-stage operand interface: ID-stage operand forwarding, load-use hazard detection and the ID/EXE pipeline register.
- Drives EXE_Qa, EXE_Qb, EXE_Ext_imm, EXE_write_reg, EXE_PC_plus4, EXE_Aluc and EXE_Aluqb into the execute stage.
- Consumes the execute stage's combinational EXE_Alu result and the MEM-stage results for forwarding.
- Raises Stall to freeze PC and the IF/ID register on a load-use hazard.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register-number width.

Ports:
- Clk  in  1  clock; all state on rising edge.
- Rst  in  1  synchronous reset, active-high.
- ID_Qa, ID_Qb  in  WIDTH  register-file read data.
- ID_Rs, ID_Rt  in  RADDR  source register numbers.
- ID_Use_rs, ID_Use_rt  in  1  instruction reads rs / rt.
- ID_Ext_imm, ID_PC_plus4  in  WIDTH  extended immediate, PC+4.
- ID_write_reg  in  RADDR  destination register.
- ID_Aluc  in  2  ALU op.
- ID_Aluqb  in  1  1 = Qb operand, 0 = immediate.
- ID_Wreg, ID_Reg2reg, ID_Wmem  in  1  register write, load (result from memory), store.
- ID_Valid  in  1  ID holds a real instruction.
- Flush  in  1  branch/jump taken; kill the instruction in ID.
- EXE_Alu  in  WIDTH  ALU result of the instruction currently in EXE.
- MEM_Alu, MEM_Mdata  in  WIDTH  MEM-stage ALU result, load data.
- MEM_Wreg, MEM_Reg2reg  in  1  MEM-stage control.
- MEM_write_reg  in  RADDR  MEM-stage destination.
- EXE_Qa, EXE_Qb, EXE_Ext_imm, EXE_PC_plus4  out  WIDTH  registered operands.
- EXE_write_reg  out  RADDR  registered destination.
- EXE_Aluc  out  2  registered ALU op.
- EXE_Aluqb  out  1  registered operand select.
- EXE_Wreg, EXE_Reg2reg, EXE_Wmem, EXE_Valid  out  1  registered control.
- FwdA, FwdB  out  2  combinational forwarding selects.
- Stall  out  1  combinational load-use stall.

Behaviour:
- Reset: all registered outputs are 0 on the first edge with Rst=1, regardless of the other inputs.
- Forward select for operand A (B is identical, using rs→rt, Qa→Qb, FwdA→FwdB):
  - 1 (EXE_Alu) if ID_Use_rs, EXE_Valid, EXE_Wreg, !EXE_Reg2reg, EXE_write_reg==ID_Rs, ID_Rs!=0.
  - else 2 (MEM_Alu) if MEM_Wreg, !MEM_Reg2reg, MEM_write_reg==ID_Rs, ID_Rs!=0.
  - else 3 (MEM_Mdata) if MEM_Wreg, MEM_Reg2reg, MEM_write_reg==ID_Rs, ID_Rs!=0.
  - else 0 (ID_Qa).
  - EXE has priority over MEM. Register 0 is never forwarded.
- Stall = ID_Valid & !Flush & EXE_Valid & EXE_Wreg & EXE_Reg2reg & EXE_write_reg!=0 & ((ID_Use_rs & EXE_write_reg==ID_Rs) | (ID_Use_rt & EXE_write_reg==ID_Rt)).
- Per-edge priority (Rst=0):
  - Flush: load a bubble.
  - Else Stall: load a bubble; the ID instruction is held upstream and re-presented.
  - Else: capture forwarded Qa/Qb and all ID fields. EXE_Wreg = ID_Wreg & ID_Valid, EXE_Wmem = ID_Wmem & ID_Valid, EXE_Valid = ID_Valid.
- Bubble: every registered output is 0, including data fields, so a bubble never writes registers or memory.
- Latency: one cycle ID→EXE. A stall inserts exactly one bubble; the next cycle the load is in MEM and FwdX=3 resolves the hazard.
- No internal state beyond the pipeline register. Any Rst cycle mid-stream discards the in-flight instruction.

Test Plan:
- Reset: Rst=1 for 1 edge with arbitrary inputs -> all EXE_* outputs = 0, EXE_Valid = 0.
- EXE forward: EXE holds add writing r3 with EXE_Alu=0x0000_0010; ID reads rs=3, ID_Qa=0xDEAD -> FwdA=1, EXE_Qa=0x10 after the edge.
- Dual-source priority: EXE and MEM both write r5 (EXE_Alu=7, MEM_Alu=9); ID uses rt=5 -> FwdB=1, EXE_Qb=7. With EXE_Wreg=0 -> FwdB=2, EXE_Qb=9.
- Load-use: EXE is lw to r4; ID add uses rs=4 -> Stall=1, next EXE_Valid=0, EXE_Wreg=0. The following cycle, with MEM_Mdata=0x1234, gives FwdA=3 and EXE_Qa=0x1234, Stall=0.
- r0 guard: EXE writes r0 with EXE_Alu=5; ID reads rs=0, ID_Qa=0 -> FwdA=0, EXE_Qa=0, no stall even if EXE is a load to r0.
- Flush during stall: load-use condition with Flush=1 -> Stall=0, bubble loaded. Store in ID with Flush=1 -> EXE_Wmem=0.
